accel_stream_writer: RTL and testbench

// - Stream-to-memory writer on the mem_clk side of the accelerator output buffer.
// - Consumes the AXI-stream drained from the accel->mem FIFO (to_mem) and writes
//   LEN consecutive words into core memory starting at a byte base address.
// - Single-word req/ack memory write port; software-style start/busy/done control.

---
 rtl/accel_stream_writer_if.sv | 32 +++
 rtl/accel_stream_writer.sv | 204 ++++++++++++++++++++
 tb/tb_accel_stream_writer.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/accel_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : accel_stream_writer_if
// Brief    : AXI-stream beat interface (tdata/tvalid/tready/tlast) feeding
//            the stream writer.
// Revision : 1.0
// ============================================================================

interface accel_stream_writer_if #(
    parameter int DATA_W = 32
) ();
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/accel_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : accel_stream_writer
// Brief    : Drains an AXI-stream into core memory as LEN consecutive words
//            over a single-word req/ack write port, with start/busy/done
//            control. Optional tlast checking is enabled by the macro
//            ACCEL_WR_TLAST_CHK_EN.
// Revision : 1.0
// ============================================================================

module accel_stream_writer #(
    parameter int BUFF_WORD = 32,
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16
) (
    input  logic                 mem_clk,
    input  logic                 rst_n,
    accel_stream_writer_if.slave from_buff,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     len_words,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_W-1:0]     words_wr,
    output logic [1:0]           tlast_err,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BUFF_WORD-1:0] mem_wdata,
    input  logic                 mem_ack
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BUFF_WORD / 8);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BEAT = 2'd1,
        WRITE     = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LEN_W-1:0]  len_q;
    logic              abort_hold;
    logic              tready;
    logic              beat_fire;
    logic              last_word;
    logic              trunc;
    logic              start_ok;
    logic              abort_now;

    // The word currently being moved is the final one of the programmed length.
    assign last_word = (words_wr == (len_q - LEN_ONE));
    assign start_ok  = (state == IDLE) && start;
    assign abort_now = abort || abort_hold;

    // ------------------------------------------------------------------------
    // Next-state and stream handshake
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tready     = 1'b0;
        beat_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_words != '0) ? WAIT_BEAT : FINISH;
                end
            end
            WAIT_BEAT: begin
                // Abort withholds tready so no beat is half-consumed.
                tready    = !abort;
                beat_fire = from_buff.tvalid && !abort;
                if (beat_fire) begin
                    state_next = WRITE;
                end else if (abort) begin
                    state_next = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (abort_now) begin
                        state_next = IDLE;
                    end else if (last_word || trunc) begin
                        state_next = FINISH;
                    end else begin
                        state_next = WAIT_BEAT;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign from_buff.tready = tready;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath, memory request and status
    // ------------------------------------------------------------------------
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            words_wr   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            len_q      <= '0;
            abort_hold <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr   <= base_addr;
                        len_q      <= len_words;
                        words_wr   <= '0;
                        abort_hold <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                WAIT_BEAT: begin
                    if (beat_fire) begin
                        mem_wdata <= from_buff.tdata;
                        mem_req   <= 1'b1;
                    end else if (abort) begin
                        busy <= 1'b0;
                    end
                end
                WRITE: begin
                    // An abort seen while the request is outstanding is
                    // remembered so the transfer stops after this ack.
                    if (abort) begin
                        abort_hold <= 1'b1;
                    end
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        words_wr <= words_wr + LEN_ONE;
                        mem_addr <= mem_addr + ADDR_STEP;
                        if (abort_now) begin
                            busy <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional tlast framing check
    // ------------------------------------------------------------------------
`ifdef ACCEL_WR_TLAST_CHK_EN
    logic [1:0] tlast_err_q;
    logic       trunc_q;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            tlast_err_q <= 2'b00;
            trunc_q     <= 1'b0;
        end else if (start_ok) begin
            tlast_err_q <= 2'b00;
            trunc_q     <= 1'b0;
        end else if (beat_fire) begin
            if (from_buff.tlast && !last_word) begin
                tlast_err_q[0] <= 1'b1;
                trunc_q        <= 1'b1;
            end else if (!from_buff.tlast && last_word) begin
                tlast_err_q[1] <= 1'b1;
            end
        end
    end

    assign tlast_err = tlast_err_q;
    assign trunc     = trunc_q;
`else
    assign tlast_err = 2'b00;
    assign trunc     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_accel_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_accel_stream_writer
// Brief    : Randomized scoreboard bench for accel_stream_writer.
// Revision : 1.0
// ============================================================================

module tb_accel_stream_writer;

    localparam int BW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } wr_t;

    typedef struct {
        logic [BW-1:0] data;
        logic          last;
    } beat_t;

    logic          mem_clk = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len_words = '0;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_wr;
    logic [1:0]    tlast_err;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;

    accel_stream_writer_if #(.DATA_W(BW)) ax ();

    accel_stream_writer #(.BUFF_WORD(BW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .mem_clk   (mem_clk),
        .rst_n     (rst_n),
        .from_buff (ax),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .words_wr  (words_wr),
        .tlast_err (tlast_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack)
    );

    always #5 mem_clk = ~mem_clk;

    wr_t   exp_q[$];
    beat_t beat_q[$];
    int    gap_pct   = 0;
    int    ack_delay = 1;
    int    tests     = 0;
    int    fails     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream source: presents queued beats with random idle gaps.
    initial begin : src
        logic fire;
        ax.tvalid = 1'b0;
        ax.tdata  = '0;
        ax.tlast  = 1'b0;
        forever begin
            @(negedge mem_clk);
            fire = ax.tvalid && ax.tready;
            @(posedge mem_clk);
            #1;
            if (fire) begin
                if (beat_q.size() > 0) void'(beat_q.pop_front());
                ax.tvalid = 1'b0;
            end
            if (!ax.tvalid && beat_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                ax.tvalid = 1'b1;
                ax.tdata  = beat_q[0].data;
                ax.tlast  = beat_q[0].last;
            end
        end
    end

    // Memory responder: acks after ack_delay cycles of a pending request.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        forever begin
            @(posedge mem_clk);
            #1;
            if (!mem_req) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (!mem_ack) begin
                if (cnt >= ack_delay) mem_ack = 1'b1;
                else cnt++;
            end
        end
    end

    // Monitor: scoreboard on each write handshake, stability while pending.
    initial begin : mon
        logic          pend;
        logic [AW-1:0] pa;
        logic [BW-1:0] pd;
        wr_t           e;
        pend = 1'b0;
        pa   = '0;
        pd   = '0;
        forever begin
            @(negedge mem_clk);
            if (mem_req) begin
                chk("tready_low_in_write", 64'(ax.tready), 64'd0);
                if (pend) begin
                    chk("addr_stable", 64'(mem_addr), 64'(pa));
                    chk("data_stable", 64'(mem_wdata), 64'(pd));
                end
                if (mem_ack) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                        chk("wr_data", 64'(mem_wdata), 64'(e.data));
                    end
                end
            end
            pend = mem_req && !mem_ack;
            pa   = mem_addr;
            pd   = mem_wdata;
        end
    end

    // Reference model: builds the beat list and the writes/flags it must yield.
    // tl_idx: -2 random tlast, -1 tlast on final beat, >=0 tlast on that beat only.
    task automatic build(input logic [AW-1:0] base, input int len, input int tl_idx,
                         output int nwr, output logic [1:0] err);
        beat_t b;
        beat_t beats[$];
        wr_t   w;
        for (int i = 0; i < len; i++) begin
            b.data = $urandom;
            if (tl_idx == -2)      b.last = 1'($urandom_range(0, 1));
            else if (tl_idx == -1) b.last = (i == len - 1);
            else                   b.last = (i == tl_idx);
            beats.push_back(b);
        end
        nwr = len;
        err = 2'b00;
`ifdef ACCEL_WR_TLAST_CHK_EN
        begin
            int first;
            first = -1;
            for (int i = 0; i < len; i++) begin
                if (beats[i].last) begin
                    first = i;
                    break;
                end
            end
            if (first >= 0 && first < len - 1) begin
                nwr = first + 1;
                err = 2'b01;
            end else if (len > 0 && !beats[len-1].last) begin
                err = 2'b10;
            end
        end
`endif
        for (int i = 0; i < nwr; i++) begin
            w.addr = base + AW'(4 * i);
            w.data = beats[i].data;
            exp_q.push_back(w);
        end
        foreach (beats[i]) beat_q.push_back(beats[i]);
    endtask

    task automatic flush();
        beat_q.delete();
        ax.tvalid = 1'b0;
        ax.tlast  = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input int len);
        @(posedge mem_clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        len_words = LW'(len);
    endtask

    task automatic end_start();
        @(posedge mem_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int len, input int gap,
                            input int dly, input int tl_idx);
        int         nwr;
        logic [1:0] err;
        int         cyc;
        gap_pct   = gap;
        ack_delay = dly;
        pulse_start(base, len);
        build(base, len, tl_idx, nwr, err);
        end_start();
        @(negedge mem_clk);
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("tready_after_start", 64'(ax.tready), 64'd1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge mem_clk);
            cyc++;
        end
        chk("done_seen", 64'(done), 64'd1);
        chk("busy_low_at_done", 64'(busy), 64'd0);
        chk("words_wr", 64'(words_wr), 64'(nwr));
        chk("tlast_err", 64'(tlast_err), 64'(err));
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
        @(negedge mem_clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        flush();
        exp_q.delete();
    endtask

    task automatic wait_req();
        int cyc;
        cyc = 0;
        @(negedge mem_clk);
        while (!mem_req && cyc < 200) begin
            @(negedge mem_clk);
            cyc++;
        end
        chk("mem_req_rises", 64'(mem_req), 64'd1);
    endtask

    initial begin : main
        int         cyc;
        int         nwr;
        logic [1:0] err;
        logic       saw_done;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_tready", 64'(ax.tready), 64'd0);
        chk("rst_words_wr", 64'(words_wr), 64'd0);
        chk("rst_tlast_err", 64'(tlast_err), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(posedge mem_clk);
        #1;
        rst_n = 1'b1;

        run_xfer(32'h0000_0100, 4, 0, 1, -1);

        // Empty transfer: busy for one cycle, done the next, no stream or memory activity.
        pulse_start(32'h0000_0200, 0);
        end_start();
        @(negedge mem_clk);
        chk("len0_busy", 64'(busy), 64'd1);
        chk("len0_done_early", 64'(done), 64'd0);
        chk("len0_tready", 64'(ax.tready), 64'd0);
        @(negedge mem_clk);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_busy_end", 64'(busy), 64'd0);
        chk("len0_no_req", 64'(mem_req), 64'd0);
        @(negedge mem_clk);
        chk("len0_done_pulse", 64'(done), 64'd0);

        run_xfer(32'h0000_1000, 3, 60, 5, -1);
        run_xfer(32'hFFFF_FFFC, 2, 0, 1, -1);

        // Abort while the first write awaits its ack: that write completes, then idle.
        gap_pct   = 0;
        ack_delay = 5;
        pulse_start(32'h0000_3000, 4);
        build(32'h0000_3000, 1, -1, nwr, err);
        beat_q.delete();
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b.data = (i == 0) ? exp_q[0].data : $urandom;
            b.last = 1'b0;
            beat_q.push_back(b);
        end
        end_start();
        wait_req();
        @(posedge mem_clk);
        #1;
        abort    = 1'b1;
        saw_done = 1'b0;
        cyc      = 0;
        @(negedge mem_clk);
        while (busy && cyc < 100) begin
            @(negedge mem_clk);
            if (done) saw_done = 1'b1;
            cyc++;
        end
        chk("abort_busy_low", 64'(busy), 64'd0);
        chk("abort_no_done", 64'(saw_done || done), 64'd0);
        chk("abort_words_wr", 64'(words_wr), 64'd1);
        chk("abort_req_low", 64'(mem_req), 64'd0);
        chk("abort_writes_done", 64'(exp_q.size()), 64'd0);
        @(posedge mem_clk);
        #1;
        abort = 1'b0;
        flush();
        exp_q.delete();
        run_xfer(32'h0000_4000, 3, 20, 2, -1);

`ifdef ACCEL_WR_TLAST_CHK_EN
        run_xfer(32'h0000_5000, 5, 0, 1, 2);
        run_xfer(32'h0000_6000, 4, 0, 1, 99);
`endif

        for (int t = 0; t < 10; t++) begin
            run_xfer($urandom & 32'hFFFF_FFFC, $urandom_range(1, 8), $urandom_range(0, 60),
                     $urandom_range(0, 4), -2);
        end

        // Asynchronous reset in the middle of a write.
        gap_pct   = 0;
        ack_delay = 5;
        pulse_start(32'h0000_7000, 4);
        build(32'h0000_7000, 4, -1, nwr, err);
        end_start();
        wait_req();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", 64'(mem_req), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_tready", 64'(ax.tready), 64'd0);
        flush();
        exp_q.delete();
        repeat (2) @(posedge mem_clk);
        #1;
        rst_n = 1'b1;
        run_xfer(32'h0000_8000, 3, 10, 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
